// File: rtl/reorder_frame_sequencer.sv
// Frame sequencer for the 64-word 4x4-block transpose stage: buffers one frame
// word-serially, then replays it either block-transposed or in input order.
module reorder_frame_sequencer #(
  parameter int WIDTH = 32,
  parameter int NBLK  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_bypass,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             frame_done
);

  localparam int N  = 16 * NBLK;
  localparam int AW = $clog2(N);
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  localparam logic [1:0] FILL  = 2'd0;
  localparam logic [1:0] ARM   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state_r;
  logic [AW-1:0]    wr_cnt_r;
  logic [AW-1:0]    rd_cnt_r;
  logic             bypass_r;
  logic [WIDTH-1:0] mem [N];
  logic [WIDTH-1:0] out_data_r;
  logic             out_last_r;
  logic             frame_done_r;

  logic             in_hs_s;
  logic             out_hs_s;
  logic [AW-1:0]    rd_idx_s;
  logic [AW-1:0]    rd_addr_s;

  // Output index k maps to source 16b+4c+r: swap the row and column fields
  // inside each 16-word block (NBLK is a power of two, at least 2).
  function automatic logic [AW-1:0] src_addr(input logic [AW-1:0] k, input logic byp);
    logic [AW-1:0] a;
    if (byp) begin
      a = k;
    end else begin
      a = {k[AW-1:4], k[1:0], k[3:2]};
    end
    return a;
  endfunction

  // Handshakes and the index of the word to preload into the output register
  always_comb begin
    in_hs_s  = in_valid && (state_r == FILL);
    out_hs_s = out_ready && (state_r == DRAIN);
    if (state_r == ARM) begin
      rd_idx_s = '0;
    end else begin
      rd_idx_s = rd_cnt_r + AW'(1);
    end
    rd_addr_s = src_addr(rd_idx_s, bypass_r);
  end

  // Frame buffer write port; contents need no reset
  always_ff @(posedge clk) begin
    if (in_hs_s) mem[wr_cnt_r] <= in_data;
  end

  // Sequencing FSM, counters and the registered output word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= FILL;
      wr_cnt_r     <= '0;
      rd_cnt_r     <= '0;
      bypass_r     <= 1'b0;
      out_data_r   <= '0;
      out_last_r   <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      case (state_r)
        FILL: begin
          if (in_hs_s) begin
            if (wr_cnt_r == '0) bypass_r <= cfg_bypass;
            if (wr_cnt_r == LAST) begin
              wr_cnt_r <= '0;
              state_r  <= ARM;
            end else begin
              wr_cnt_r <= wr_cnt_r + AW'(1);
            end
          end
        end
        ARM: begin
          rd_cnt_r   <= '0;
          out_data_r <= mem[rd_addr_s];
          out_last_r <= 1'b0;
          state_r    <= DRAIN;
        end
        DRAIN: begin
          // Stalled cycles leave data, last and count untouched
          if (out_hs_s) begin
            if (rd_cnt_r == LAST) begin
              rd_cnt_r     <= '0;
              out_last_r   <= 1'b0;
              frame_done_r <= 1'b1;
              state_r      <= FILL;
            end else begin
              rd_cnt_r   <= rd_idx_s;
              out_data_r <= mem[rd_addr_s];
              out_last_r <= (rd_idx_s == LAST);
            end
          end
        end
        default: begin
          state_r  <= FILL;
          wr_cnt_r <= '0;
          rd_cnt_r <= '0;
        end
      endcase
    end
  end

  assign in_ready   = (state_r == FILL);
  assign out_valid  = (state_r == DRAIN);
  assign out_data   = out_data_r;
  assign out_last   = out_last_r;
  assign frame_done = frame_done_r;
  assign busy       = (state_r != FILL) || (wr_cnt_r != '0);

endmodule

// File: tb/tb_reorder_frame_sequencer.sv
// Randomized bench for reorder_frame_sequencer against a queue-based frame model.
module tb_reorder_frame_sequencer;

  localparam int WIDTH = 32;
  localparam int NBLK  = 4;
  localparam int N     = 16 * NBLK;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_bypass = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready, out_valid, out_last, busy, frame_done;
  logic [WIDTH-1:0] out_data;

  always #5 clk = ~clk;

  reorder_frame_sequencer #(.WIDTH(WIDTH), .NBLK(NBLK)) dut (
    .clk(clk), .rst(rst), .cfg_bypass(cfg_bypass),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  int errors = 0;
  int checks = 0;

  // Model: words of the frame being filled, words still owed downstream
  logic [WIDTH-1:0] inq[$];
  logic [WIDTH-1:0] outq[$];
  bit  cap_bypass = 1'b0;
  bit  arm_pend   = 1'b0;
  bit  done_pend  = 1'b0;
  int  cyc        = 0;
  int  popped     = 0;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Called at a falling edge: check outputs, drive inputs, advance the model
  task automatic tick(input bit iv, input logic [WIDTH-1:0] d, input bit cb, input bit ordy);
    bit exp_rdy, exp_ov, hs_in, hs_out;
    exp_rdy = (outq.size() == 0);
    exp_ov  = (outq.size() != 0) && !arm_pend;
    check_eq("in_ready", in_ready, exp_rdy);
    check_eq("out_valid", out_valid, exp_ov);
    check_eq("frame_done", frame_done, done_pend);
    check_eq("busy", busy, (inq.size() != 0) || (outq.size() != 0));
    if (exp_ov) begin
      check_eq("out_data", out_data, outq[0]);
      check_eq("out_last", out_last, outq.size() == 1);
    end else begin
      check_eq("out_last_idle", out_last, 1'b0);
    end
    in_valid   = iv;
    in_data    = d;
    cfg_bypass = cb;
    out_ready  = ordy;
    arm_pend   = 1'b0;
    done_pend  = 1'b0;
    hs_in  = iv && exp_rdy;
    hs_out = exp_ov && ordy;
    if (hs_out) begin
      void'(outq.pop_front());
      popped++;
      if (outq.size() == 0) done_pend = 1'b1;
    end
    if (hs_in) begin
      if (inq.size() == 0) cap_bypass = cb;
      inq.push_back(d);
      if (inq.size() == N) begin
        for (int j = 0; j < N; j++) begin
          int b, r, c;
          b = j / 16;
          r = (j % 16) / 4;
          c = j % 4;
          outq.push_back(cap_bypass ? inq[j] : inq[16*b + 4*c + r]);
        end
        inq.delete();
        arm_pend = 1'b1;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // One frame: words base+i, optional mid-frame cfg flip, random input gaps,
  // consumer mode 0=always ready, 1=1,0,0,1 pattern, 2=random.
  task automatic run_frame(input logic [WIDTH-1:0] base, input bit cb0, input int flip_at,
                           input int gap_pct, input int rdy_mode, input bit hold_next,
                           input logic [WIDTH-1:0] next_base, input int abort_in, input int abort_out);
    bit filled = 1'b0;
    int start_pop = popped;
    for (int n = 0; n < 3000; n++) begin
      bit iv, cb, ordy;
      logic [WIDTH-1:0] d;
      if (outq.size() != 0) filled = 1'b1;
      if (filled && outq.size() == 0) return;
      if (abort_in >= 0 && inq.size() == abort_in) return;
      if (abort_out >= 0 && (popped - start_pop) == abort_out) return;
      if (!filled) begin
        iv = (inq.size() == 0) || (int'($urandom_range(99)) >= gap_pct);
        d  = base + WIDTH'(inq.size());
        cb = (flip_at >= 0 && inq.size() >= flip_at) ? ~cb0 : cb0;
      end else begin
        iv = hold_next;
        d  = next_base;
        cb = $urandom_range(1);
      end
      case (rdy_mode)
        0:       ordy = 1'b1;
        1:       ordy = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: ordy = $urandom_range(1);
      endcase
      tick(iv, d, cb, ordy);
    end
    checks++;
    errors++;
    $display("FAIL frame_timeout: got no completion expected completion within 3000 cycles");
  endtask

  // Asynchronous reset asserted between clock edges
  task automatic do_reset();
    #1 rst = 1'b1;
    #1;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_out_data", out_data, '0);
    check_eq("rst_out_last", out_last, 1'b0);
    check_eq("rst_frame_done", frame_done, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    inq.delete();
    outq.delete();
    arm_pend  = 1'b0;
    done_pend = 1'b0;
    in_valid  = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_eq("init_out_valid", out_valid, 1'b0);
    check_eq("init_out_data", out_data, '0);
    check_eq("init_frame_done", frame_done, 1'b0);
    check_eq("init_busy", busy, 1'b0);
    rst = 1'b0;
    tick(1'b0, '0, 1'b0, 1'b1);

    run_frame(32'h0, 1'b0, -1, 0, 0, 1'b0, '0, -1, -1);
    tick(1'b0, '0, 1'b0, 1'b1);
    run_frame(32'hA000, 1'b1, 10, 0, 0, 1'b0, '0, -1, -1);
    tick(1'b0, '0, 1'b0, 1'b1);
    run_frame(32'h0, 1'b0, -1, 0, 1, 1'b0, '0, -1, -1);
    tick(1'b0, '0, 1'b0, 1'b1);

    // Back-to-back frames with word 0 of the next frame pending during drain
    run_frame(32'd0, 1'b0, -1, 30, 2, 1'b1, 32'd100, -1, -1);
    run_frame(32'd100, 1'b0, -1, 30, 2, 1'b0, '0, -1, -1);
    tick(1'b0, '0, 1'b0, 1'b1);

    // Reset during fill, then during drain, then a clean frame
    run_frame(32'h5000, 1'b0, -1, 20, 0, 1'b0, '0, 30, -1);
    do_reset();
    tick(1'b0, '0, 1'b0, 1'b1);
    run_frame(32'h6000, 1'b0, -1, 20, 0, 1'b0, '0, -1, 20);
    do_reset();
    tick(1'b0, '0, 1'b0, 1'b1);
    run_frame(32'h7000, 1'b0, -1, 20, 2, 1'b0, '0, -1, -1);
    tick(1'b0, '0, 1'b0, 1'b1);

    for (int f = 0; f < 3; f++) begin
      run_frame($urandom, 1'($urandom_range(1)), int'($urandom_range(63)), 25, 2,
                1'b1, 32'hBEEF0000, -1, -1);
    end
    repeat (3) tick(1'b0, '0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reorder_frame_sequencer.md
Name: reorder_frame_sequencer

Overview:
- Sequences the 64-word, 4x4-block transpose stage.
- Accepts a frame of 64 32-bit words one word per handshake into a single frame buffer, then emits the frame one word per handshake.
- Output is either block-transposed or passed through in order, selected per frame.
- Sits between the word-serial producer and downstream consumers, so the 64-wide permutation never needs a 64-port bus.

Parameters:
- WIDTH, 32, data word width
- NBLK, 4, number of 16-word (4x4) blocks per frame; frame length N = 16*NBLK

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- cfg_bypass  input  1  1 = emit frame in input order, 0 = emit block-transposed; sampled on first accepted word of a frame
- in_valid  input  1  producer has a word
- in_ready  output  1  block can accept a word this cycle
- in_data  input  WIDTH  input word
- out_valid  output  1  out_data holds a valid word
- out_ready  input  1  consumer accepts the word
- out_data  output  WIDTH  output word
- out_last  output  1  high with the final (index N-1) output word of a frame
- busy  output  1  high whenever state != FILL or wr_cnt != 0
- frame_done  output  1  one-cycle pulse in the cycle after the last output handshake

Behaviour:
- Reset (async, rst=1): state=FILL, wr_cnt=0, rd_cnt=0, bypass_q=0. Output values during reset: in_ready=1 once rst deasserts, out_valid=0, out_last=0, frame_done=0, busy=0, out_data=0. Buffer contents are don't-care.
- States:
  - FILL: in_ready=1, out_valid=0.
    - Each in_valid&in_ready cycle writes buf[wr_cnt]=in_data and increments wr_cnt (6 bits for NBLK=4).
    - On the accept with wr_cnt==0, bypass_q<=cfg_bypass. cfg_bypass is ignored for the rest of the frame.
    - On the accept with wr_cnt==N-1: wr_cnt<=0, next state=ARM.
  - ARM: exactly one cycle. in_ready=0, out_valid=0. Registers the first read address so out_data is driven from a register. Next state=DRAIN, rd_cnt=0.
  - DRAIN: in_ready=0, out_valid=1, out_data=buf[src(rd_cnt)] from a registered read.
    - Each out_valid&out_ready advances rd_cnt.
    - out_last=1 when rd_cnt==N-1.
    - On the handshake with rd_cnt==N-1: state<=FILL, rd_cnt<=0, frame_done=1 in the next cycle.
- Address map: k = rd_cnt, with b=k[5:4], r=k[3:2], c=k[1:0].
  - Transposed (bypass_q=0): src(k)=16b+4c+r, i.e. out[16b+4r+c]=in[16b+4c+r].
  - Bypass (bypass_q=1): src(k)=k.
- Backpressure: with out_ready=0 in DRAIN, out_data, out_last and rd_cnt hold stable and out_valid stays 1. No word is skipped or duplicated.
- Latency: the first output word is valid 2 cycles after the cycle that accepted input word N-1 (one ARM cycle, then DRAIN). Minimum frame period is N+1+N cycles.
- No overlap between frames: in_ready=0 from ARM through the final DRAIN handshake. in_ready returns to 1 in the cycle after that handshake, the same cycle frame_done pulses.
- Simultaneous events: in_valid held high in ARM/DRAIN has no effect; the word stays pending at the producer. cfg_bypass changes mid-frame have no effect.
- Reset mid-operation: a partial FILL or DRAIN is abandoned with no output. The next word accepted after reset is word 0 of a new frame.
- Counters never wrap silently. wr_cnt/rd_cnt return to 0 only through the N-1 transitions or reset.

Test Plan:
- Transposed frame, in_data=i for i=0..63, cfg_bypass=0, out_ready=1 -> outputs 0,4,8,12,1,5,9,13,2,6,10,14,3,7,11,15,16,20,...,63. out_last only with 63. frame_done pulses once. First out_valid exactly 2 cycles after word 63 is accepted.
- Bypass frame, in_data=0xA000+i, cfg_bypass=1 on word 0 then toggled to 0 at word 10 -> outputs 0xA000..0xA03F in order. The mid-frame toggle is ignored.
- Backpressure: transposed frame with out_ready toggling 1,0,0,1 pattern -> out_data stable while stalled. Output sequence identical to the first test. No extra or missing words.
- Input gaps: in_valid low on random cycles during FILL, in_valid held high through ARM/DRAIN -> in_ready=0 in ARM/DRAIN. Exactly 64 words consumed per frame. Two back-to-back frames (values i and 100+i) each correctly transposed.
- Async reset: assert rst after 30 words accepted, then after 20 output words of a later frame -> outputs zero, in_ready=1 after release, busy=0, no frame_done. A fresh frame afterwards is output correctly.
- Boundary: confirm out_last coincides with rd_cnt=63 only. Confirm the in_ready rise and the frame_done pulse occur in the same cycle, and that word 0 of the next frame can be accepted that cycle.
